// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the double-buffered frame VRAM.
//   state_t         - control FSM states (IDLE, CLEAR, SWAP_PEND)
//   DEFAULT_PIXEL_W - default bits per pixel
//   DEFAULT_DEPTH   - default pixels per frame (128x96)
//   RD_LATENCY      - read latency in cycles; 2 when VRAM_OUT_REG_EN is defined, else 1
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_PEND = 2'd2
    } state_t;

    localparam int DEFAULT_PIXEL_W = 1;
    localparam int DEFAULT_DEPTH   = 12288;

`ifdef VRAM_OUT_REG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/vram_bank.sv
// vram_bank: one frame bank, simple dual-port inferred block RAM.
//   clk   - clock
//   we    - write enable; waddr/wdata written at the clock edge
//   re    - read enable; rdata loads mem[raddr] at the clock edge, else holds
// Contents are not reset.
module vram_bank #(
    parameter int  PIXEL_W = 1,
    parameter int  DEPTH   = 12288,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vram_dbuf_frame.sv
// vram_dbuf_frame: double-buffered video RAM with a back-bank clear engine.
// The scan side reads the front bank, the drawing side writes the back bank,
// and front/back only exchange on frame_start so the display never tears.
//   clk, reset               - clock, synchronous active-high reset
//   frame_start              - start-of-vblank pulse; the only moment a swap may happen
//   rd_en/rd_addr            - front-bank read; rd_pixel/rd_valid follow after RD_LATENCY
//   wr_valid/wr_ready        - back-bank write handshake (ready only while idle)
//   wr_addr/wr_pixel         - write address and data
//   wr_drop                  - pulse after an accepted write that was out of range
//   swap_req/swap_ack        - swap request, pulse when the swap happened
//   front_bank               - bank currently being displayed
//   clear_req/clear_busy     - fill back bank with CLEAR_VAL, engine busy flag
// Build option: define VRAM_OUT_REG_EN to add an output register on the read
// path (read latency 2 instead of 1).
module vram_dbuf_frame
    import vram_pkg::*;
#(
    parameter int                 PIXEL_W   = DEFAULT_PIXEL_W,
    parameter int                 DEPTH     = DEFAULT_DEPTH,
    parameter logic [PIXEL_W-1:0] CLEAR_VAL = '0,
    localparam int                ADDR_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_pixel,
    output logic               rd_valid,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_pixel,
    output logic               wr_drop,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               front_bank,
    input  logic               clear_req,
    output logic               clear_busy
);

    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state, state_nxt;
    logic               pend, pend_nxt;
    logic               do_swap;
    logic               cnt_load;
    logic [ADDR_W-1:0]  clr_cnt;

    logic               wr_acc, wr_inrng, rd_inrng;
    logic               bk_we;
    logic [ADDR_W-1:0]  bk_waddr;
    logic [PIXEL_W-1:0] bk_wdata;
    logic [PIXEL_W-1:0] q0, q1;

    logic               sel_p0, inrng_p0, vld_p0;
    logic [PIXEL_W-1:0] pix_p0, pix_hold;

    assign clear_busy = (state == CLEAR);
    assign wr_ready   = (state == IDLE) && !reset;
    assign wr_acc     = wr_valid && wr_ready;
    assign wr_inrng   = {1'b0, wr_addr} < DEPTH_X;
    assign rd_inrng   = {1'b0, rd_addr} < DEPTH_X;

    // Back-bank write port: the clear engine owns it while clearing; wr_ready
    // is low then, so there is never a competing drawing-side write.
    always_comb begin
        bk_we    = wr_acc && wr_inrng;
        bk_waddr = wr_addr;
        bk_wdata = wr_pixel;
        if (state == CLEAR) begin
            bk_we    = 1'b1;
            bk_waddr = clr_cnt;
            bk_wdata = CLEAR_VAL;
        end
    end

    // Writes go to ~front_bank, reads come from front_bank.
    vram_bank #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH)) u_bank0 (
        .clk   (clk),
        .we    (bk_we && front_bank),
        .waddr (bk_waddr),
        .wdata (bk_wdata),
        .re    (rd_en && rd_inrng && !front_bank),
        .raddr (rd_addr),
        .rdata (q0)
    );

    vram_bank #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH)) u_bank1 (
        .clk   (clk),
        .we    (bk_we && !front_bank),
        .waddr (bk_waddr),
        .wdata (bk_wdata),
        .re    (rd_en && rd_inrng && front_bank),
        .raddr (rd_addr),
        .rdata (q1)
    );

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        do_swap   = 1'b0;
        cnt_load  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    // Clear wins; a simultaneous swap waits until the clear ends.
                    state_nxt = CLEAR;
                    cnt_load  = 1'b1;
                    if (swap_req) pend_nxt = 1'b1;
                end else if (swap_req) begin
                    if (frame_start) begin
                        do_swap = 1'b1;
                    end else begin
                        state_nxt = SWAP_PEND;
                        pend_nxt  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (swap_req) pend_nxt = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = pend_nxt ? SWAP_PEND : IDLE;
                end
            end
            SWAP_PEND: begin
                if (frame_start) begin
                    do_swap   = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= 1'b0;
            front_bank <= 1'b0;
            swap_ack   <= 1'b0;
            wr_drop    <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            pend       <= pend_nxt;
            front_bank <= front_bank ^ do_swap;
            swap_ack   <= do_swap;
            wr_drop    <= wr_acc && !wr_inrng;
            if (cnt_load) begin
                clr_cnt <= '0;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // ---- p0: RAM read cycle; bank select and range flag travel with vld_p0 ----
    always_ff @(posedge clk) begin
        sel_p0   <= front_bank;
        inrng_p0 <= rd_inrng;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            pix_hold <= '0;
        end else begin
            vld_p0   <= rd_en;
            pix_hold <= pix_p0;
        end
    end

    // Out-of-range reads return 0; with no read the last pixel is held.
    assign pix_p0 = !vld_p0   ? pix_hold :
                    !inrng_p0 ? '0       :
                    sel_p0    ? q1       : q0;

`ifdef VRAM_OUT_REG_EN
    // ---- p1: optional output register ----
    logic               vld_p1;
    logic [PIXEL_W-1:0] pix_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            pix_p1 <= pix_p0;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_pixel = pix_p1;
`else
    assign rd_valid = vld_p0;
    assign rd_pixel = pix_p0;
`endif

endmodule

// File: tb/tb_vram_dbuf_frame.sv
// Bench for vram_dbuf_frame: directed steps plus a randomized phase checked
// against an array model of the two banks. A second small instance with a
// non power-of-two depth exercises out-of-range addresses.
module tb_vram_dbuf_frame;
    import vram_pkg::*;

    localparam int PW = 4;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int OD = 40;
    localparam int L  = RD_LATENCY;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          frame_start, rd_en, wr_valid, swap_req, clear_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] wr_pixel, rd_pixel;
    logic          rd_valid, wr_ready, wr_drop, swap_ack, front_bank, clear_busy;

    logic          o_frame_start, o_rd_en, o_wr_valid, o_swap_req, o_clear_req;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [PW-1:0] o_wr_pixel, o_rd_pixel;
    logic          o_rd_valid, o_wr_ready, o_wr_drop, o_swap_ack, o_front_bank, o_clear_busy;

    vram_dbuf_frame #(.PIXEL_W(PW), .DEPTH(D), .CLEAR_VAL(4'hA)) u_dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_pixel(rd_pixel), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_pixel(wr_pixel),
        .wr_drop(wr_drop), .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    vram_dbuf_frame #(.PIXEL_W(PW), .DEPTH(OD), .CLEAR_VAL(4'hA)) u_oor (
        .clk(clk), .reset(reset), .frame_start(o_frame_start),
        .rd_en(o_rd_en), .rd_addr(o_rd_addr), .rd_pixel(o_rd_pixel), .rd_valid(o_rd_valid),
        .wr_valid(o_wr_valid), .wr_ready(o_wr_ready), .wr_addr(o_wr_addr), .wr_pixel(o_wr_pixel),
        .wr_drop(o_wr_drop), .swap_req(o_swap_req), .swap_ack(o_swap_ack), .front_bank(o_front_bank),
        .clear_req(o_clear_req), .clear_busy(o_clear_busy)
    );

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_expect(input int a, input logic [PW-1:0] e, input string tag);
        rd_en = 1'b1;
        rd_addr = a[AW-1:0];
        step();
        rd_en = 1'b0;
        for (int i = 1; i < L; i++) step();
        chk({tag, "_vld"}, rd_valid, 1'b1);
        chk({tag, "_pix"}, rd_pixel, e);
        step();
        chk({tag, "_vld_off"}, rd_valid, 1'b0);
        chk({tag, "_hold"}, rd_pixel, e);
    endtask

    task automatic o_rd_expect(input int a, input logic [PW-1:0] e, input string tag);
        o_rd_en = 1'b1;
        o_rd_addr = a[AW-1:0];
        step();
        o_rd_en = 1'b0;
        for (int i = 1; i < L; i++) step();
        chk({tag, "_vld"}, o_rd_valid, 1'b1);
        chk({tag, "_pix"}, o_rd_pixel, e);
    endtask

    // Reference model: contents of both banks and the displayed bank index.
    typedef struct {
        logic          v;
        logic [PW-1:0] p;
    } rexp_t;

    logic [PW-1:0] bank_m [2][D];
    int            front_m;
    logic [PW-1:0] last_p;
    rexp_t         rq[$];

    int n, ack_seen, rdy_bad;

    initial begin
        reset = 1'b1;
        {frame_start, rd_en, wr_valid, swap_req, clear_req} = '0;
        rd_addr = '0; wr_addr = '0; wr_pixel = '0;
        {o_frame_start, o_rd_en, o_wr_valid, o_swap_req, o_clear_req} = '0;
        o_rd_addr = '0; o_wr_addr = '0; o_wr_pixel = '0;

        // Reset values
        step();
        chk("rst_front", front_bank, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_pixel", rd_pixel, 4'h0);
        chk("rst_swap_ack", swap_ack, 1'b0);
        chk("rst_wr_drop", wr_drop, 1'b0);
        chk("rst_clear_busy", clear_busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_wr_ready", wr_ready, 1'b1);

        // Write addr 5 into bank 1, deferred swap on a later frame_start
        wr_valid = 1'b1; wr_addr = 6'd5; wr_pixel = 4'h1;
        step();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("pend_wr_ready", wr_ready, 1'b0);
        ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (swap_ack !== 1'b0 || front_bank !== 1'b0) ack_seen++;
        end
        chk("pend_no_early_swap", ack_seen, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("swap1_ack", swap_ack, 1'b1);
        chk("swap1_front", front_bank, 1'b1);
        step();
        chk("swap1_ack_once", swap_ack, 1'b0);
        rd_expect(5, 4'h1, "rd5");

        // Immediate swap from IDLE
        swap_req = 1'b1; frame_start = 1'b1;
        step();
        swap_req = 1'b0; frame_start = 1'b0;
        chk("imm_ack", swap_ack, 1'b1);
        chk("imm_front", front_bank, 1'b0);
        step();
        chk("imm_ack_once", swap_ack, 1'b0);
        chk("imm_front_stable", front_bank, 1'b0);

        // Second swap_req while pending is absorbed
        swap_req = 1'b1;
        step();
        step();
        swap_req = 1'b0;
        chk("dbl_no_swap_yet", front_bank, 1'b0);
        frame_start = 1'b1;
        step();
        chk("dbl_ack", swap_ack, 1'b1);
        chk("dbl_front", front_bank, 1'b1);
        step();
        frame_start = 1'b0;
        chk("dbl_single_toggle", front_bank, 1'b1);
        chk("dbl_single_ack", swap_ack, 1'b0);

        // Clear of back bank (bank 0); swap requested and frame_start seen mid-clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0; ack_seen = 0; rdy_bad = 0;
        while (clear_busy === 1'b1 && n < 200) begin
            n++;
            if (wr_ready !== 1'b0) rdy_bad++;
            swap_req    = (n == 10);
            frame_start = (n == 30);
            step();
            if (swap_ack !== 1'b0) ack_seen++;
        end
        swap_req = 1'b0; frame_start = 1'b0;
        chk("clr_busy_cycles", n, D);
        chk("clr_wr_ready_low", rdy_bad, 0);
        chk("clr_no_swap", ack_seen, 0);
        chk("clr_front_kept", front_bank, 1'b1);
        chk("clr_then_pending", wr_ready, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("clr_swap_ack", swap_ack, 1'b1);
        chk("clr_swap_front", front_bank, 1'b0);

        // Stream reads of the whole cleared bank
        rdy_bad = 0;
        for (int i = 0; i < D + L - 1; i++) begin
            rd_en   = (i < D);
            rd_addr = i[AW-1:0];
            step();
            if (i >= L - 1 && (rd_valid !== 1'b1 || rd_pixel !== 4'hA)) rdy_bad++;
        end
        rd_en = 1'b0;
        chk("clr_all_reads_A", rdy_bad, 0);

        // Clear the other bank too so the model starts fully known
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("clr2_busy_cycles", n, D);
        chk("clr2_idle", wr_ready, 1'b1);

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) bank_m[b][a] = 4'hA;
        front_m = 0;
        last_p  = 4'hA;

        // Randomized writes, reads and immediate swaps against the model
        for (int it = 0; it < 300; it++) begin
            logic do_sw;
            rexp_t e;
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 6'($urandom_range(0, D - 1));
            wr_pixel = 4'($urandom);
            rd_en    = 1'($urandom_range(0, 1));
            rd_addr  = 6'($urandom_range(0, D - 1));
            do_sw    = ($urandom_range(0, 7) == 0);
            swap_req = do_sw;
            frame_start = do_sw;
            chk("rnd_wr_ready", wr_ready, 1'b1);
            e.v = rd_en;
            e.p = rd_en ? bank_m[front_m][rd_addr] : last_p;
            last_p = e.p;
            rq.push_back(e);
            if (wr_valid) bank_m[1 - front_m][wr_addr] = wr_pixel;
            if (do_sw) front_m = 1 - front_m;
            step();
            chk("rnd_front", front_bank, front_m[0]);
            chk("rnd_swap_ack", swap_ack, do_sw);
            if (rq.size() >= L) begin
                e = rq.pop_front();
                chk("rnd_rd_valid", rd_valid, e.v);
                chk("rnd_rd_pixel", rd_pixel, e.p);
            end
        end
        {wr_valid, rd_en, swap_req, frame_start} = '0;

        // Reset in the middle of a clear, with bank 1 displayed
        if (front_m == 0) begin
            swap_req = 1'b1; frame_start = 1'b1;
            step();
            swap_req = 1'b0; frame_start = 1'b0;
        end
        chk("pre_rst_front", front_bank, 1'b1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("mid_clr_busy", clear_busy, 1'b1);
        reset = 1'b1;
        step();
        chk("mid_rst_clear_busy", clear_busy, 1'b0);
        chk("mid_rst_front", front_bank, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("after_rst_wr_ready", wr_ready, 1'b1);
        chk("after_rst_idle", clear_busy, 1'b0);

        // Out-of-range write and read on the depth-40 instance
        o_wr_valid = 1'b1; o_wr_addr = 6'd0; o_wr_pixel = 4'h3;
        step();
        o_wr_addr = 6'd3; o_wr_pixel = 4'h5;
        step();
        o_wr_addr = 6'(OD); o_wr_pixel = 4'hF;
        chk("oor_wr_ready", o_wr_ready, 1'b1);
        step();
        o_wr_valid = 1'b0;
        chk("oor_wr_drop", o_wr_drop, 1'b1);
        step();
        chk("oor_wr_drop_once", o_wr_drop, 1'b0);
        o_swap_req = 1'b1; o_frame_start = 1'b1;
        step();
        o_swap_req = 1'b0; o_frame_start = 1'b0;
        chk("oor_front", o_front_bank, 1'b1);
        o_rd_expect(OD + 3, 4'h0, "oor_rd_hi");
        o_rd_expect(0, 4'h3, "oor_rd0");
        o_rd_expect(3, 4'h5, "oor_rd3");
        o_rd_expect(OD + 3, 4'h0, "oor_rd_hi2");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
